// File: rtl/bla_addsub_pipe.sv
// bla_addsub_pipe: pipelined look-ahead add/subtract, one WIDTH/STAGES slice per stage, valid/ready with full backpressure
module bla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int S  = WIDTH / STAGES;
  localparam int NB = S / GROUP;
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  // Inverting the minuend turns the borrow chain into a carry chain: g = ~a&b, p = ~(a^b).
  function automatic logic [S:0] cla(input logic [S-1:0] x, input logic [S-1:0] y, input logic ci, input logic md);
    logic [S-1:0] g, p, c;
    logic [NB:0]  bc;
    logic         gg, gp;
    g     = (md ? x : ~x) & y;
    p     = (md ? x : ~x) ^ y;
    c     = '0;
    bc[0] = ci;
    for (int j = 0; j < NB; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        gp = gp & p[j*GROUP+i];
      end
      bc[j+1]    = gg | (gp & bc[j]);
      c[j*GROUP] = bc[j];
      for (int i = 1; i < GROUP; i++)
        c[j*GROUP+i] = g[j*GROUP+i-1] | (p[j*GROUP+i-1] & c[j*GROUP+i-1]);
    end
    return {bc[NB], x ^ y ^ c};
  endfunction
  for (genvar k = 0; k < STAGES; k++) begin : st
    localparam int LO = k * S;
    localparam int RW = WIDTH - LO;
    logic [RW-1:0]   ia, ib;
    logic            ic, im, iv;
    logic [LO+S-1:0] nr;
    logic [S:0]      sum;
    assign sum = cla(ia[S-1:0], ib[S-1:0], ic, im);
    if (k == 0) begin : g_in
      assign ia = a;
      assign ib = b;
      assign ic = bin;
      assign im = mode;
      assign iv = in_valid;
      assign nr = sum[S-1:0];
    end else begin : g_in
      assign ia = st[k-1].g_reg.ra;
      assign ib = st[k-1].g_reg.rb;
      assign ic = st[k-1].g_reg.rc;
      assign im = st[k-1].g_reg.rm;
      assign iv = st[k-1].g_reg.rv;
      assign nr = {sum[S-1:0], st[k-1].g_reg.rr};
    end
    // Only the unconsumed operand bits move on; finished result bits accumulate below them.
    if (k < STAGES - 1) begin : g_reg
      logic [RW-S-1:0] ra, rb;
      logic [LO+S-1:0] rr;
      logic            rc, rm, rv;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          ra <= '0;
          rb <= '0;
          rr <= '0;
          rc <= 1'b0;
          rm <= 1'b0;
          rv <= 1'b0;
        end else if (adv) begin
          ra <= ia[RW-1:S];
          rb <= ib[RW-1:S];
          rr <= nr;
          rc <= sum[S];
          rm <= im;
          rv <= iv;
        end
    end else begin : g_out
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          result    <= '0;
          bout      <= 1'b0;
          zero      <= 1'b0;
          ovf       <= 1'b0;
          out_valid <= 1'b0;
        end else if (adv) begin
          result    <= nr;
          bout      <= sum[S];
          zero      <= ~|nr;
          ovf       <= (im ? ia[RW-1] == ib[RW-1] : ia[RW-1] != ib[RW-1]) && (nr[WIDTH-1] != ia[RW-1]);
          out_valid <= iv;
        end
    end
  end
endmodule

// File: tb/tb_bla_addsub_pipe.sv
// tb_bla_addsub_pipe: randomized and directed checks against an arithmetic reference model
module tb_bla_addsub_pipe;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;
  logic        clk = 0, rst_n = 1, in_valid = 0, mode = 0, bin = 0, out_ready = 1;
  logic        in_ready, out_valid, bout, zero, ovf;
  logic [31:0] a = 0, b = 0, result;
  int          checks = 0, errors = 0, cyc_n = 0, outs = 0;
  bit          chk_lat = 1;
  logic [34:0] exq[$];
  int          acq[$];
  bla_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .bin(bin), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .bout(bout), .zero(zero), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // {ovf, zero, bout, result} from plain wide and signed arithmetic
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic m, input logic ci);
    logic [32:0] f;
    longint      sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    f  = m ? {1'b0, x} + {1'b0, y} + 33'(ci) : {1'b0, x} - {1'b0, y} - 33'(ci);
    s  = m ? sx + sy + longint'(ci) : sx - sy - longint'(ci);
    return {s > MAXS || s < MINS, f[31:0] == 32'd0, f[32], f[31:0]};
  endfunction
  task automatic cyc(input logic v, input logic [31:0] x, input logic [31:0] y, input logic m, input logic ci,
                     input logic ordy, output logic took);
    logic [34:0] e;
    int          t;
    @(negedge clk);
    in_valid = v; a = x; b = y; mode = m; bin = ci; out_ready = ordy;
    #1;
    cyc_n++;
    if (exq.size() == 0) begin
      if (out_valid) chk("spurious", 64'(out_valid), 64'd0);
    end else if (out_valid && out_ready) begin
      e = exq.pop_front();
      t = acq.pop_front();
      outs++;
      chk("result", 64'(result), 64'(e[31:0]));
      chk("bout", 64'(bout), 64'(e[32]));
      chk("zero", 64'(zero), 64'(e[33]));
      chk("ovf", 64'(ovf), 64'(e[34]));
      if (chk_lat) chk("latency", 64'(cyc_n - t), 64'd4);
    end
    took = in_valid && in_ready;
    if (took) begin
      exq.push_back(model(x, y, m, ci));
      acq.push_back(cyc_n);
    end
  endtask
  task automatic op(input logic m, input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic t;
    cyc(1'b1, x, y, m, ci, 1'b1, t);
  endtask
  task automatic idle(input int n);
    logic t;
    repeat (n) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, t);
  endtask
  task automatic drain();
    logic t;
    for (int i = 0; i < 60 && exq.size() != 0; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, t);
    idle(2);
    chk("drain", 64'(exq.size()), 64'd0);
  endtask
  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] sa[8], sb[8], x, y, hr;
    logic        sm[8], sc[8], m, ci, took, hb, hz, ho;
    int          n, outs0;
    #2 rst_n = 0;
    #1;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(result), 64'd0);
    chk("rst_bout", 64'(bout), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    op(1'b0, 32'h0, 32'h1, 1'b0);
    idle(3);
    chk("lat_early", 64'(out_valid), 64'd0);
    idle(1);
    chk("tp1_vld", 64'(out_valid), 64'd1);
    chk("tp1_res", 64'(result), 64'hFFFFFFFF);
    chk("tp1_bout", 64'(bout), 64'd1);
    op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    op(1'b0, 32'h0, 32'h0, 1'b1);
    op(1'b0, 32'h80000000, 32'h1, 1'b0);
    op(1'b1, 32'h7FFFFFFF, 32'h1, 1'b0);
    op(1'b1, 32'hFFFFFFFF, 32'h1, 1'b0);
    drain();
    for (int i = 0; i < 32; i++) begin
      op(1'b0, 32'h0, 32'h1 << i, 1'b0);
      op(1'b1, 32'h0, 32'h1 << i, 1'b0);
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom; sb[i] = $urandom;
      sm[i] = 1'($urandom_range(0, 1)); sc[i] = 1'($urandom_range(0, 1));
    end
    chk_lat = 0;
    outs0 = outs;
    n = 0;
    for (int c = 1; n < 8 && c <= 40; c++) begin
      cyc(1'b1, sa[n], sb[n], sm[n], sc[n], !(c >= 6 && c <= 8), took);
      if (c >= 6 && c <= 8) begin
        chk("stall_rdy", 64'(in_ready), 64'd0);
        chk("stall_vld", 64'(out_valid), 64'd1);
        if (c == 6) begin
          hr = result; hb = bout; hz = zero; ho = ovf;
        end else begin
          chk("hold_res", 64'(result), 64'(hr));
          chk("hold_flags", 64'({bout, zero, ovf}), 64'({hb, hz, ho}));
        end
      end
      if (took) n++;
    end
    drain();
    chk("stream_cnt", 64'(outs - outs0), 64'd8);
    x = $urandom; y = $urandom; m = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
    for (int c = 0, k = 0; k < 40 && c < 400; c++) begin
      cyc(1'b1, x, y, m, ci, $urandom_range(0, 3) != 0, took);
      if (took) begin
        k++;
        x = $urandom; y = $urandom; m = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      end
    end
    drain();
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1, took);
    for (int i = 0; i < 10 && !out_valid; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, took);
    chk("pre_rst_vld", 64'(out_valid), 64'd1);
    rst_n = 0;
    #1;
    chk("async_vld", 64'(out_valid), 64'd0);
    chk("async_res", 64'(result), 64'd0);
    chk("async_rdy", 64'(in_ready), 64'd1);
    exq.delete();
    acq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("stale", 64'(out_valid), 64'd0);
    end
    chk_lat = 1;
    op(1'b0, $urandom, $urandom, 1'b1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
